// File: rtl/alu_md_pkg.sv
// Shared opcode constants, FSM state type and opcode classifier for alu_md.
// Pure declarations; no logic, no latency.
package alu_pkg;

  localparam logic [3:0] OP_ADD   = 4'b0000;
  localparam logic [3:0] OP_MULTU = 4'b0001;
  localparam logic [3:0] OP_ADD2  = 4'b0010;
  localparam logic [3:0] OP_MULT  = 4'b0011;
  localparam logic [3:0] OP_AND   = 4'b0100;
  localparam logic [3:0] OP_OR    = 4'b0101;
  localparam logic [3:0] OP_SLL   = 4'b0110;
  localparam logic [3:0] OP_SRL   = 4'b0111;
  localparam logic [3:0] OP_SRA   = 4'b1000;
  localparam logic [3:0] OP_DIVU  = 4'b1001;
  localparam logic [3:0] OP_SUB   = 4'b1010;
  localparam logic [3:0] OP_SUB2  = 4'b1011;
  localparam logic [3:0] OP_DIV   = 4'b1100;
  localparam logic [3:0] OP_SUB3  = 4'b1101;
  localparam logic [3:0] OP_MFHI  = 4'b1110;
  localparam logic [3:0] OP_MFLO  = 4'b1111;

  typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

  function automatic logic is_iter_op(input logic [3:0] op);
    return (op == OP_MULTU) || (op == OP_MULT) || (op == OP_DIVU) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/alu_md_if.sv
// Request/response bundle for alu_md: operands and opcode in, result and HI/LO out.
// Request accepted only while in_ready is high; no queuing of refused requests.
interface alu_md_if #(parameter int WIDTH = 32);
  localparam int SW = $clog2(WIDTH);

  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [SW-1:0]    shamt;
  logic [3:0]       alu_control;
  logic             is_shift;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             out_valid;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output a, b, shamt, alu_control, is_shift, in_valid,
    input  in_ready, result, zero, out_valid, hi, lo
  );

  modport slave (
    input  a, b, shamt, alu_control, is_shift, in_valid,
    output in_ready, result, zero, out_valid, hi, lo
  );
endinterface

// File: rtl/alu_md_iter.sv
// Shift-add multiplier / restoring divider on operand magnitudes, one bit per i_step cycle.
// Results valid after WIDTH steps; sign correction and divide-by-zero override are combinational.
module alu_md_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic             i_step,
  input  logic [3:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  logic [2*WIDTH-1:0] r_p;
  logic [WIDTH-1:0]   r_m;
  logic [WIDTH-1:0]   r_a;
  logic               r_div;
  logic               r_neg_lo;
  logic               r_neg_hi;
  logic               r_dz;

  logic               w_signed;
  logic               w_div;
  logic               w_sa;
  logic               w_sb;
  logic [WIDTH-1:0]   w_ma;
  logic [WIDTH-1:0]   w_mb;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_sh;
  logic [WIDTH:0]     w_diff;
  logic [2*WIDTH-1:0] w_mul_nxt;
  logic [2*WIDTH-1:0] w_div_nxt;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_q;
  logic [WIDTH-1:0]   w_r;

  assign w_signed = (i_op == OP_MULT) || (i_op == OP_DIV);
  assign w_div    = (i_op == OP_DIV)  || (i_op == OP_DIVU);
  assign w_sa     = w_signed & i_a[WIDTH-1];
  assign w_sb     = w_signed & i_b[WIDTH-1];
  assign w_ma     = w_sa ? -i_a : i_a;
  assign w_mb     = w_sb ? -i_b : i_b;

  // Multiply: low half holds the multiplier, shifted out as the product shifts in.
  assign w_sum     = {1'b0, r_p[2*WIDTH-1:WIDTH]} + (r_p[0] ? {1'b0, r_m} : '0);
  assign w_mul_nxt = {w_sum, r_p[WIDTH-1:1]};

  // Divide: upper half is the partial remainder, low half the dividend/quotient.
  assign w_sh      = {r_p[2*WIDTH-1:WIDTH], r_p[WIDTH-1]};
  assign w_diff    = w_sh - {1'b0, r_m};
  assign w_div_nxt = w_diff[WIDTH] ? {w_sh[WIDTH-1:0], r_p[WIDTH-2:0], 1'b0}
                                   : {w_diff[WIDTH-1:0], r_p[WIDTH-2:0], 1'b1};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_p      <= '0;
      r_m      <= '0;
      r_a      <= '0;
      r_div    <= 1'b0;
      r_neg_lo <= 1'b0;
      r_neg_hi <= 1'b0;
      r_dz     <= 1'b0;
    end else if (i_load) begin
      r_p      <= {{WIDTH{1'b0}}, w_ma};
      r_m      <= w_mb;
      r_a      <= i_a;
      r_div    <= w_div;
      r_neg_lo <= w_sa ^ w_sb;
      r_neg_hi <= w_sa;
      r_dz     <= w_div && (i_b == '0);
    end else if (i_step) begin
      r_p <= r_div ? w_div_nxt : w_mul_nxt;
    end
  end

  assign w_prod = r_neg_lo ? -r_p : r_p;
  assign w_q    = r_neg_lo ? -r_p[WIDTH-1:0] : r_p[WIDTH-1:0];
  assign w_r    = r_neg_hi ? -r_p[2*WIDTH-1:WIDTH] : r_p[2*WIDTH-1:WIDTH];

  always_comb begin
    o_hi = w_prod[2*WIDTH-1:WIDTH];
    o_lo = w_prod[WIDTH-1:0];
    if (r_div) begin
      o_hi = r_dz ? r_a : w_r;
      o_lo = r_dz ? '1  : w_q;
    end
  end

endmodule

// File: rtl/alu_md.sv
// ALU with iterative mul/div: single-cycle ops register on the accept edge; mul/div take WIDTH+1 cycles.
// in_ready is high only in IDLE; requests seen while busy are dropped, never queued.
module alu_md
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic     clk,
  input  logic     reset,
  alu_md_if.slave  bus
);

  localparam int SW = $clog2(WIDTH);

  state_t           r_state;
  state_t           w_next;
  logic [SW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  logic             w_accept;
  logic             w_iter_op;
  logic             w_load;
  logic             w_step;
  logic             w_last;
  logic [SW-1:0]    w_amt;
  logic [WIDTH-1:0] w_alu;
  logic [WIDTH-1:0] w_it_hi;
  logic [WIDTH-1:0] w_it_lo;

  assign w_accept  = bus.in_valid && (r_state == IDLE);
  assign w_iter_op = is_iter_op(bus.alu_control);
  assign w_last    = (r_cnt == SW'(WIDTH - 1));
  assign w_amt     = bus.is_shift ? bus.shamt : bus.b[SW-1:0];

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    w_step = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept && w_iter_op) begin
          w_next = ITER;
          w_load = 1'b1;
        end
      end
      ITER: begin
        w_step = 1'b1;
        if (w_last) w_next = DONE;
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_alu = '0;
    case (bus.alu_control)
      OP_ADD, OP_ADD2:          w_alu = bus.a + bus.b;
      OP_SUB, OP_SUB2, OP_SUB3: w_alu = bus.a - bus.b;
      OP_AND:                   w_alu = bus.a & bus.b;
      OP_OR:                    w_alu = bus.a | bus.b;
      OP_SLL:                   w_alu = bus.a << w_amt;
      OP_SRL:                   w_alu = bus.a >> w_amt;
      OP_SRA:                   w_alu = WIDTH'($signed(bus.a) >>> w_amt);
      OP_MFHI:                  w_alu = r_hi;
      OP_MFLO:                  w_alu = r_lo;
      default:                  w_alu = '0;
    endcase
  end

  alu_md_iter #(.WIDTH(WIDTH)) u_iter (
    .clk    (clk),
    .reset  (reset),
    .i_load (w_load),
    .i_step (w_step),
    .i_op   (bus.alu_control),
    .i_a    (bus.a),
    .i_b    (bus.b),
    .o_hi   (w_it_hi),
    .o_lo   (w_it_lo)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt       <= '0;
      r_result    <= '0;
      r_zero      <= 1'b1;
      r_out_valid <= 1'b0;
      r_hi        <= '0;
      r_lo        <= '0;
    end else begin
      r_out_valid <= 1'b0;
      if (r_state == ITER) r_cnt <= w_last ? '0 : r_cnt + SW'(1);
      if (w_accept && !w_iter_op) begin
        r_result    <= w_alu;
        r_zero      <= (w_alu == '0);
        r_out_valid <= 1'b1;
      end
      if (r_state == DONE) begin
        r_hi        <= w_it_hi;
        r_lo        <= w_it_lo;
        r_result    <= w_it_lo;
        r_zero      <= (w_it_lo == '0);
        r_out_valid <= 1'b1;
      end
    end
  end

  assign bus.in_ready  = (r_state == IDLE);
  assign bus.result    = r_result;
  assign bus.zero      = r_zero;
  assign bus.out_valid = r_out_valid;
  assign bus.hi        = r_hi;
  assign bus.lo        = r_lo;

endmodule

// File: tb/tb_alu_md.sv
// Directed vectors for alu_md (WIDTH=32); expected responses are queued at issue and checked by a monitor.
module tb_alu_md;
  import alu_pkg::*;

  localparam int W = 32;

  typedef struct packed {
    logic [W-1:0] result;
    logic         zero;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  alu_md_if #(.WIDTH(W)) bus();
  alu_md #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

  exp_t         exp_q[$];
  string        name_q[$];
  int           n_cmp = 0;
  int           n_fail = 0;
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  // Monitor: every out_valid pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!reset && bus.out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_out_valid: got result 0x%0h, want no response", bus.result);
      end else begin
        exp_t  e;
        string nm;
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        chk({nm, " result"}, 64'(bus.result), 64'(e.result));
        chk({nm, " zero"},   64'(bus.zero),   64'(e.zero));
        chk({nm, " hi"},     64'(bus.hi),     64'(e.hi));
        chk({nm, " lo"},     64'(bus.lo),     64'(e.lo));
      end
    end
  end

  task automatic push(input string nm, input logic [W-1:0] res, input logic z,
                      input logic [W-1:0] h, input logic [W-1:0] l);
    exp_t e;
    e.result = res; e.zero = z; e.hi = h; e.lo = l;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic drive(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [4:0] sh, input logic is_sh);
    bus.alu_control = op; bus.a = a; bus.b = b; bus.shamt = sh; bus.is_shift = is_sh;
    bus.in_valid = 1'b1;
  endtask

  task automatic single(input string nm, input logic [3:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [4:0] sh, input logic is_sh,
                        input logic [W-1:0] res, input logic z);
    push(nm, res, z, m_hi, m_lo);
    drive(op, a, b, sh, is_sh);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int exp_k);
    int k = 0;
    while (bus.out_valid !== 1'b1 && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    chk({nm, " latency"}, 64'(k), 64'(exp_k));
  endtask

  task automatic iter(input string nm, input logic [3:0] op, input logic [W-1:0] a,
                      input logic [W-1:0] b, input logic [W-1:0] h, input logic [W-1:0] l);
    push(nm, l, (l == '0), h, l);
    drive(op, a, b, 5'd0, 1'b0);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    wait_done(nm, W + 1);
    m_hi = h; m_lo = l;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, want completion");
    $fatal(1);
  end

  initial begin
    bus.a = '0; bus.b = '0; bus.shamt = '0; bus.alu_control = '0;
    bus.is_shift = 1'b0; bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("reset result",    64'(bus.result),    64'h0);
    chk("reset zero",      64'(bus.zero),      64'h1);
    chk("reset out_valid", 64'(bus.out_valid), 64'h0);
    chk("reset hi",        64'(bus.hi),        64'h0);
    chk("reset lo",        64'(bus.lo),        64'h0);
    chk("reset in_ready",  64'(bus.in_ready),  64'h1);

    single("add",     OP_ADD,  32'd5,          32'd7,          5'd0,  1'b0, 32'd12,         1'b0);
    single("sub_eq",  OP_SUB,  32'd9,          32'd9,          5'd0,  1'b0, 32'd0,          1'b1);
    single("sub3",    OP_SUB3, 32'd10,         32'd3,          5'd0,  1'b0, 32'd7,          1'b0);
    single("and",     OP_AND,  32'h0000_F0F0,  32'h0000_FF00,  5'd0,  1'b0, 32'h0000_F000,  1'b0);
    single("or",      OP_OR,   32'h0000_F0F0,  32'h0000_0F0F,  5'd0,  1'b0, 32'h0000_FFFF,  1'b0);
    single("sra_imm", OP_SRA,  32'h8000_0000,  32'h8000_0000,  5'd4,  1'b1, 32'hF800_0000,  1'b0);
    single("sll_var", OP_SLL,  32'd1,          32'h0000_0021,  5'd7,  1'b0, 32'd2,          1'b0);
    single("srl_imm", OP_SRL,  32'h8000_0000,  32'd0,          5'd31, 1'b1, 32'd1,          1'b0);
    single("add_wrap",OP_ADD2, 32'hFFFF_FFFF,  32'd1,          5'd0,  1'b0, 32'd0,          1'b1);
    @(posedge clk); #1;

    iter("mult", OP_MULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    single("mfhi", OP_MFHI, 32'd0, 32'd0, 5'd0, 1'b0, 32'hFFFF_FFFF, 1'b0);
    single("mflo", OP_MFLO, 32'd0, 32'd0, 5'd0, 1'b0, 32'hFFFF_FFEB, 1'b0);

    // DIV with an ADD attempt and operand changes while busy.
    push("div", 32'hFFFF_FFFD, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    drive(OP_DIV, 32'hFFFF_FFF9, 32'd2, 5'd0, 1'b0);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    drive(OP_ADD, 32'd100, 32'd200, 5'd0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk("busy in_ready", 64'(bus.in_ready), 64'h0);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    wait_done("div", W + 1 - 7);
    m_hi = 32'hFFFF_FFFF; m_lo = 32'hFFFF_FFFD;
    @(posedge clk); #1;

    iter("divu_by0",  OP_DIVU,  32'd9,         32'd0,         32'd9,         32'hFFFF_FFFF);
    iter("div_ovf",   OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000);
    iter("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1);
    iter("div_by0",   OP_DIV,   32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF);
    iter("divu",      OP_DIVU,  32'd100,       32'd7,         32'd2,         32'd14);

    // Abort a MULTU at ITER cycle 10 with reset.
    drive(OP_MULTU, 32'd1234, 32'd5678, 5'd0, 1'b0);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("abort in_ready",  64'(bus.in_ready),  64'h1);
    chk("abort hi",        64'(bus.hi),        64'h0);
    chk("abort lo",        64'(bus.lo),        64'h0);
    chk("abort out_valid", 64'(bus.out_valid), 64'h0);
    chk("abort result",    64'(bus.result),    64'h0);
    repeat (40) @(posedge clk);
    #1;
    m_hi = '0; m_lo = '0;
    single("mflo_after_abort", OP_MFLO, 32'd0, 32'd0, 5'd0, 1'b0, 32'd0, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard drained", 64'(exp_q.size()), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
